// File: rtl/capture_ila.sv
// ============================================================================
// Module   : capture_ila
// Function : Ring-buffer logic-analyser capture with pre-trigger depth, masked
//            level/edge trigger, abort and ordered streaming readout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module capture_ila #(
    parameter int unsigned DATA_W = 45,
    parameter int unsigned TRIG_W = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              abort,
    input  logic [TRIG_W-1:0] trig_mask,
    input  logic [TRIG_W-1:0] trig_value,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pre_trig,
    input  logic [DATA_W-1:0] data_in,
    input  logic [TRIG_W-1:0] trig_in,
    input  logic              rd_en,
    output logic [2:0]        state,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last
);

    localparam int unsigned       c_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_LAST  = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q;
    logic [TRIG_W-1:0]   mask_q;
    logic [TRIG_W-1:0]   value_q;
    logic                edge_q;
    logic [ADDR_W-1:0]   pre_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   post_rem_q;
    logic                match_prev_q;
    logic [ADDR_W-1:0]   trig_addr_q;
    logic                triggered_q;
    logic                done_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [ADDR_W-1:0]   rd_cnt_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                rd_last_q;
    logic [DATA_W-1:0]   mem_q [c_DEPTH];

    logic                w_capture;
    logic                w_match;
    logic                w_hit;
    logic [ADDR_W-1:0]   w_post_len;

    assign w_capture  = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    // Unmasked bits are don't-care; an all-zero mask therefore matches every cycle.
    assign w_match    = &(~mask_q | ~(trig_in ^ value_q));
    assign w_hit      = edge_q ? (w_match & ~match_prev_q) : w_match;
    assign w_post_len = c_LAST - pre_q;

    always_ff @(posedge clk) begin
        if (w_capture) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            value_q      <= '0;
            edge_q       <= 1'b0;
            pre_q        <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            post_rem_q   <= '0;
            match_prev_q <= 1'b0;
            trig_addr_q  <= '0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;

            if (w_capture) begin
                wr_ptr_q     <= wr_ptr_q + c_ONE;
                match_prev_q <= w_match;
            end

            // A read accepted in the arm cycle still returns its data next cycle.
            if ((state_q == S_DONE) && rd_en) begin
                rd_data_q  <= mem_q[rd_ptr_q];
                rd_valid_q <= 1'b1;
                rd_last_q  <= (rd_cnt_q == c_LAST);
                rd_ptr_q   <= rd_ptr_q + c_ONE;
                rd_cnt_q   <= rd_cnt_q + c_ONE;
            end

            if (abort) begin
                state_q     <= S_IDLE;
                triggered_q <= 1'b0;
                done_q      <= 1'b0;
                rd_valid_q  <= 1'b0;
                rd_last_q   <= 1'b0;
            end else if (arm && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
                mask_q       <= trig_mask;
                value_q      <= trig_value;
                edge_q       <= trig_edge;
                pre_q        <= pre_trig;
                wr_ptr_q     <= '0;
                cnt_q        <= '0;
                match_prev_q <= 1'b0;
                triggered_q  <= 1'b0;
                done_q       <= 1'b0;
                state_q      <= (pre_trig != '0) ? S_PRE : S_WAIT;
            end else begin
                case (state_q)
                    S_PRE: begin
                        cnt_q <= cnt_q + c_ONE;
                        if (cnt_q == (pre_q - c_ONE)) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (w_hit) begin
                            trig_addr_q <= wr_ptr_q;
                            triggered_q <= 1'b1;
                            post_rem_q  <= w_post_len;
                            if (w_post_len == '0) begin
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                                rd_ptr_q <= wr_ptr_q - pre_q;
                                rd_cnt_q <= '0;
                            end else begin
                                state_q <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        post_rem_q <= post_rem_q - c_ONE;
                        if (post_rem_q == c_ONE) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            rd_ptr_q <= trig_addr_q - pre_q;
                            rd_cnt_q <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign state     = state_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign trig_addr = trig_addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_ila.sv
// ============================================================================
// Module   : tb_capture_ila
// Function : Scoreboard bench for capture_ila with a history-based reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_capture_ila;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  trig_mask = '0;
    logic [7:0]  trig_value = '0;
    logic        trig_edge = 1'b0;
    logic [3:0]  pre_trig = '0;
    logic [44:0] data_in = '0;
    logic [7:0]  trig_in = '0;
    logic        rd_en = 1'b0;
    logic [2:0]  state;
    logic        triggered;
    logic        done;
    logic [3:0]  trig_addr;
    logic [44:0] rd_data;
    logic        rd_valid;
    logic        rd_last;

    capture_ila #(.DATA_W(45), .TRIG_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .pre_trig(pre_trig), .data_in(data_in), .trig_in(trig_in), .rd_en(rd_en),
        .state(state), .triggered(triggered), .done(done), .trig_addr(trig_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last)
    );

    typedef struct packed {
        logic [44:0] d;
        logic        last;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          pc = 0;
    logic [44:0] hist_d [int];
    logic [7:0]  hist_t [int];
    exp_t        sbq [$];
    int          arm_edge = 0;
    logic [7:0]  cm = '0;
    logic [7:0]  cv = '0;
    logic        ce = 1'b0;
    int          cp = 0;
    logic [44:0] win [16];
    int          rd_k = 0;

    always #5 clk = ~clk;

    // History of what the DUT sampled at each rising edge.
    always @(posedge clk) begin
        pc = pc + 1;
        hist_d[pc] = data_in;
        hist_t[pc] = trig_in;
    end

    always @(negedge clk) begin
        data_in = {13'($urandom), 32'(pc)};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid actual=1 expected=0 at edge %0d", pc);
            end else begin
                e = sbq.pop_front();
                chk("rd_data", 64'(rd_data), 64'(e.d));
                chk("rd_last", 64'(rd_last), 64'(e.last));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic bit mt(input int p);
        return ((hist_t[p] ^ cv) & cm) == 8'h00;
    endfunction

    task automatic do_arm(input logic [7:0] m, input logic [7:0] v, input logic e, input logic [3:0] p);
        trig_mask = m; trig_value = v; trig_edge = e; pre_trig = p;
        cm = m; cv = v; ce = e; cp = int'(p);
        arm = 1'b1;
        arm_edge = pc + 1;
        tick();
        arm = 1'b0;
        trig_mask = 8'($urandom); trig_value = 8'($urandom);
        trig_edge = 1'($urandom); pre_trig = 4'($urandom);
    endtask

    task automatic wait_done(input bit rnd, output bit ok);
        int n;
        int J;
        bit m;
        bit mp;
        n = 0;
        ok = 1'b0;
        while (done !== 1'b1 && n < 400) begin
            if (rnd) trig_in = ($urandom_range(0, 2) == 0) ? cv : 8'($urandom);
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d expected=1 state=%0d", done, state);
            return;
        end
        // Trigger = first sample at or after the pre-trigger window that hits.
        J = -1;
        for (int j = cp; arm_edge + 1 + j <= pc; j++) begin
            m  = mt(arm_edge + 1 + j);
            mp = (j == 0) ? 1'b0 : mt(arm_edge + j);
            if (ce ? (m && !mp) : m) begin
                J = j;
                break;
            end
        end
        if (J < 0) begin
            checks++;
            errors++;
            $display("FAIL model_trigger actual=none expected=trigger_before_done");
            return;
        end
        chk("done_edge", 64'(pc), 64'(arm_edge + 1 + J + 15 - cp));
        chk("done_state", 64'(state), 64'd4);
        chk("triggered", 64'(triggered), 64'd1);
        chk("trig_addr", 64'(trig_addr), 64'(J % 16));
        for (int i = 0; i < 16; i++) win[i] = hist_d[arm_edge + 1 + J - cp + i];
        rd_k = 0;
        ok = 1'b1;
    endtask

    task automatic do_reads(input int n);
        int issued;
        int b;
        issued = 0;
        while (issued < n) begin
            if ($urandom_range(0, 3) != 0) begin
                rd_en = 1'b1;
                sbq.push_back('{d: win[rd_k % 16], last: ((rd_k % 16) == 15)});
                rd_k++;
                issued++;
            end else begin
                rd_en = 1'b0;
            end
            tick();
        end
        rd_en = 1'b0;
        b = 0;
        while (sbq.size() != 0 && b < 5) begin
            tick();
            b++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL read_drain actual=%0d expected=0 outstanding", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [7:0] m;
        repeat (3) tick();
        chk("rst_state", 64'(state), 0);
        chk("rst_triggered", 64'(triggered), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_trig_addr", 64'(trig_addr), 0);
        chk("rst_rd_data", 64'(rd_data), 0);
        chk("rst_rd_valid", 64'(rd_valid), 0);
        chk("rst_rd_last", 64'(rd_last), 0);
        rst_n = 1'b1;
        tick();

        // Level trigger on a single A5 after the pre window.
        trig_in = 8'h00;
        do_arm(8'hFF, 8'hA5, 1'b0, 4'd4);
        repeat (6) tick();
        trig_in = 8'hA5;
        tick();
        trig_in = 8'h00;
        wait_done(1'b0, ok);
        if (ok) do_reads(20);

        // Edge trigger: held match must not fire; re-rise must.
        trig_in = 8'hA5;
        do_arm(8'hFF, 8'hA5, 1'b1, 4'd2);
        repeat (8) tick();
        chk("edge_hold_state", 64'(state), 64'd2);
        chk("edge_hold_trig", 64'(triggered), 0);
        trig_in = 8'h00;
        tick();
        trig_in = 8'hA5;
        wait_done(1'b0, ok);
        if (ok) do_reads(16);

        // Forced trigger, no pre-trigger samples.
        do_arm(8'h00, 8'h5A, 1'b0, 4'd0);
        wait_done(1'b0, ok);
        if (ok) do_reads(16);

        // Full pre-trigger window, zero post samples.
        do_arm(8'h00, 8'h00, 1'b0, 4'd15);
        wait_done(1'b0, ok);
        if (ok) do_reads(16);

        // Asynchronous reset while in POST.
        trig_in = 8'h5A;
        do_arm(8'hFF, 8'h5A, 1'b0, 4'd3);
        repeat (6) tick();
        chk("post_state", 64'(state), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(state), 0);
        chk("arst_triggered", 64'(triggered), 0);
        chk("arst_done", 64'(done), 0);
        chk("arst_trig_addr", 64'(trig_addr), 0);
        chk("arst_rd_data", 64'(rd_data), 0);
        chk("arst_rd_valid", 64'(rd_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // PRE ignores hits; arm ignored in WAIT; abort beats arm; reads ignored in IDLE.
        trig_in = 8'h3C;
        do_arm(8'hFF, 8'h3C, 1'b0, 4'd8);
        repeat (3) tick();
        trig_in = 8'h00;
        repeat (6) tick();
        chk("pre_hit_state", 64'(state), 64'd2);
        chk("pre_hit_trig", 64'(triggered), 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_in_wait", 64'(state), 64'd2);
        abort = 1'b1;
        arm = 1'b1;
        tick();
        abort = 1'b0;
        arm = 1'b0;
        chk("abort_state", 64'(state), 0);
        chk("abort_trig", 64'(triggered), 0);
        chk("abort_done", 64'(done), 0);
        rd_en = 1'b1;
        repeat (3) tick();
        rd_en = 1'b0;
        chk("idle_rd_valid", 64'(rd_valid), 0);

        // Randomised captures.
        for (int it = 0; it < 12; it++) begin
            m = 8'($urandom);
            if (it % 3 == 0) m = m & 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("rand_abort_state", 64'(state), 0);
                chk("rand_abort_done", 64'(done), 0);
            end
            do_arm(m, 8'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            wait_done(1'b1, ok);
            if (ok) begin
                do_reads($urandom_range(8, 24));
            end else begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
        end

        tick();
        chk("scoreboard_empty", 64'(sbq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/capture_ila.md
Name: capture_ila

Overview:
- Parametrised in-fabric logic-analyser capture engine for the overclocking test platform.
- Replaces a fixed-width, vendor-core capture with a ring-buffer capture that adds:
  - configurable pre-trigger depth
  - masked level/edge trigger
  - abort
  - ordered streaming readout
- Sits beside the device under test on its clock; a host/UART controller arms it and drains the capture buffer.

Parameters:
DATA_W  45  width of captured sample
TRIG_W  8   width of trigger input bus
ADDR_W  10  log2 of buffer depth; DEPTH = 2**ADDR_W samples

Ports:
clk         in   1       capture clock, all logic rising-edge
rst_n       in   1       asynchronous active-low reset
arm         in   1       single-cycle pulse, starts a capture
abort       in   1       single-cycle pulse, returns to IDLE
trig_mask   in   TRIG_W  1 = bit participates in trigger compare
trig_value  in   TRIG_W  required value of participating bits
trig_edge   in   1       0 = level trigger, 1 = rising-edge-of-match trigger
pre_trig    in   ADDR_W  samples to keep before trigger sample
data_in     in   DATA_W  sample written every capturing cycle
trig_in     in   TRIG_W  trigger source bus
rd_en       in   1       request next sample in DONE
state       out  3       IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4
triggered   out  1       trigger seen in current capture
done        out  1       buffer complete, readable
trig_addr   out  ADDR_W  buffer address of trigger sample
rd_data     out  DATA_W  read sample
rd_valid    out  1       rd_data valid this cycle
rd_last     out  1       with rd_valid: final (DEPTH-th) sample of a pass

Behaviour:

Reset (rst_n low, async):
- state=IDLE; triggered, done, rd_valid, rd_last = 0.
- trig_addr, rd_data, all pointers/counters = 0.
- Buffer contents undefined.

Arm:
- arm honoured only in IDLE or DONE; ignored elsewhere.
- On arm, latch trig_mask, trig_value, trig_edge and pre_lat = pre_trig.
  - pre_trig = DEPTH-1 is legal and means 0 post samples.
- On arm: wr_ptr=0, count=0, match_d=0, triggered=0, done=0.
- Next state: PRE if pre_lat>0, else WAIT.

Abort:
- abort in any state → IDLE next cycle; triggered/done/rd_valid cleared.
- abort has priority over arm in the same cycle.

Capture:
- In PRE, WAIT and POST: every cycle mem[wr_ptr] <= data_in, wr_ptr += 1 mod DEPTH.
- match = AND over i of (~mask[i] | (trig_in[i] == value[i])). Mask all-zero → match every cycle (forced trigger).
- hit = match when trig_edge=0; match & ~match_d when trig_edge=1.
- match_d registers match in PRE/WAIT/POST.

PRE:
- Counts samples written; hits ignored.
- After pre_lat samples written → WAIT.
  - First WAIT cycle is cycle pre_lat+1 after arm.

WAIT:
- On hit, the sample written this cycle is the trigger sample.
- trig_addr <= wr_ptr; triggered <= 1; post_rem <= DEPTH-1-pre_lat.
- If post_rem = 0 → DONE, else → POST.
- No hit → stay; ring wraps freely.

POST:
- Writes one sample per cycle; post_rem decrements.
- When the last sample is written → DONE; done=1 from the first DONE cycle.
- Total = pre_lat pre + 1 trigger + (DEPTH-1-pre_lat) post = DEPTH samples.

DONE / readout:
- No writes in DONE.
- Read pointer initialised on entry to (trig_addr - pre_lat) mod DEPTH, i.e. the oldest sample.
- Synchronous RAM read, 1-cycle latency: rd_en in cycle N → rd_data/rd_valid in cycle N+1; pointer += 1 mod DEPTH.
- rd_last=1 with the DEPTH-th read of a pass.
- The pointer then wraps to the oldest sample, so a second pass re-reads identical data.
- Back-to-back rd_en gives one sample per cycle.
- rd_en outside DONE ignored; rd_valid=0.
- arm in DONE restarts capture; any in-flight rd_valid still completes next cycle.

Test Plan (ADDR_W=4, DEPTH=16, data_in = free-running cycle counter):
1. Reset mid-POST → all outputs 0 and state=0 immediately, without a clock edge.
2. pre_trig=4, mask=8'hFF, value=8'hA5, level; trig_in=8'hA5 once → done after 11 post samples. Readout over 16 rd_en gives 16 consecutive counter values; the 5th equals the trigger-cycle counter; rd_last on the 16th only.
3. Edge mode, trig_in held at 8'hA5 from arm onward with pre_trig=2 → no trigger; state stays 2 (WAIT). Drop to 8'h00 then back to 8'hA5 → trigger on the re-rise cycle.
4. mask=0, pre_trig=0 → trigger on first WAIT cycle; trig_addr=0; done after 15 further cycles.
5. pre_trig=15 → DONE the cycle after the trigger; the trigger sample is the last of 16 read.
6. abort together with arm while in WAIT → IDLE. A hit during PRE is ignored (triggered stays 0). rd_en in IDLE → rd_valid stays 0.
